// File: rtl/pc_next_unit.sv
// pc_next_unit
//   Fetch-stage next-PC generator and program-counter register. Each cycle
//   the next PC is picked from five sources, highest priority first:
//   trap vector, branch target, return-address stack (RAS) top, jump target
//   and sequential pc+4. The PC is held on stall (trap still wins). The RAS
//   is circular: pushing onto a full stack overwrites the oldest entry.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   stall               hold PC and RAS; only trap is honoured
//   trap                load TRAP_VECTOR
//   branch_taken/target load branch_target
//   jump/jump_target    load jump_target; with call, push the link address
//   call                qualifies jump
//   ret                 pop RAS and load the popped address
//   pc, pc_plus4        registered PC and PC+4
//   redirect            one-cycle pulse after a non-sequential PC update
//   ras_empty/ras_full  RAS occupancy flags
//   ras_ovf/ras_unf     one-cycle pulses: push on full / ret on empty
module pc_next_unit #(
  parameter int unsigned  N           = 32,
  parameter int unsigned  RAS_DEPTH   = 4,
  parameter logic [N-1:0] RESET_PC    = '0,
  parameter logic [N-1:0] TRAP_VECTOR = N'(32'h0000_0080)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         trap,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_target,
  input  logic         jump,
  input  logic         call,
  input  logic [N-1:0] jump_target,
  input  logic         ret,
  output logic [N-1:0] pc,
  output logic [N-1:0] pc_plus4,
  output logic         redirect,
  output logic         ras_empty,
  output logic         ras_full,
  output logic         ras_ovf,
  output logic         ras_unf
);

  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  localparam logic [N-1:0]  ALIGN_MASK = ~N'(3);
  localparam logic [N-1:0]  PC_STEP    = N'(4);
  localparam logic [N-1:0]  RESET_PC_A = RESET_PC & ALIGN_MASK;
  localparam logic [CW-1:0] CNT_FULL   = CW'(RAS_DEPTH);

  logic [N-1:0]  pc_q, pc_d, pc_sel;
  logic [N-1:0]  pc_plus4_q, pc_plus4_d;
  logic [N-1:0]  ras_q [RAS_DEPTH];
  logic [N-1:0]  ras_d [RAS_DEPTH];
  logic [PW-1:0] ptr_q, ptr_d, ptr_inc;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          redirect_q, redirect_d;
  logic          ras_ovf_q, ras_ovf_d;
  logic          ras_unf_q, ras_unf_d;
  logic          empty_w, full_w;

  assign empty_w = (cnt_q == '0);
  assign full_w  = (cnt_q == CNT_FULL);
  assign ptr_inc = ptr_q + PW'(1);

  always_comb begin
    pc_sel     = pc_q;
    ras_d      = ras_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    redirect_d = 1'b0;
    ras_ovf_d  = 1'b0;
    ras_unf_d  = 1'b0;

    if (trap) begin
      pc_sel     = TRAP_VECTOR;
      redirect_d = 1'b1;
    end else if (!stall) begin
      if (branch_taken) begin
        pc_sel     = branch_target;
        redirect_d = 1'b1;
      end else if (ret) begin
        if (empty_w) begin
          // Nothing to predict from: fall through sequentially.
          pc_sel    = pc_plus4_q;
          ras_unf_d = 1'b1;
        end else begin
          pc_sel     = ras_q[ptr_q];
          ptr_d      = ptr_q - PW'(1);
          cnt_d      = cnt_q - CW'(1);
          redirect_d = 1'b1;
        end
      end else if (jump) begin
        pc_sel     = jump_target;
        redirect_d = 1'b1;
        if (call) begin
          // pc_plus4_q is the link; on a full stack the slot after the top
          // holds the oldest entry, so advancing the pointer overwrites it.
          ras_d[ptr_inc] = pc_plus4_q;
          ptr_d          = ptr_inc;
          if (full_w) ras_ovf_d = 1'b1;
          else        cnt_d     = cnt_q + CW'(1);
        end
      end else begin
        pc_sel = pc_plus4_q;
      end
    end
  end

  assign pc_d       = pc_sel & ALIGN_MASK;
  assign pc_plus4_d = pc_d + PC_STEP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC_A;
      pc_plus4_q <= RESET_PC_A + PC_STEP;
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      redirect_q <= 1'b0;
      ras_ovf_q  <= 1'b0;
      ras_unf_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      ras_q      <= ras_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      redirect_q <= redirect_d;
      ras_ovf_q  <= ras_ovf_d;
      ras_unf_q  <= ras_unf_d;
    end
  end

  assign pc        = pc_q;
  assign pc_plus4  = pc_plus4_q;
  assign redirect  = redirect_q;
  assign ras_empty = empty_w;
  assign ras_full  = full_w;
  assign ras_ovf   = ras_ovf_q;
  assign ras_unf   = ras_unf_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: a directed vector table walking the main
// scenarios, a randomized run against a queue-based reference model, and an
// asynchronous reset check mid-sequence.
module tb_pc_next_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, trap, branch_taken, jump, call, ret;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc, pc_plus4;
  logic        redirect, ras_empty, ras_full, ras_ovf, ras_unf;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_redir, m_ovf, m_unf;

  pc_next_unit #(
    .N(32), .RAS_DEPTH(DEPTH), .RESET_PC(32'h0), .TRAP_VECTOR(32'h80)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .trap(trap),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .call(call), .jump_target(jump_target), .ret(ret),
    .pc(pc), .pc_plus4(pc_plus4), .redirect(redirect),
    .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, trap, br;
    logic [31:0] bt;
    logic        jump, call;
    logic [31:0] jt;
    logic        ret;
    logic [31:0] exp_pc;
    logic        exp_redir, exp_empty, exp_full, exp_ovf, exp_unf;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(
    input logic s, input logic t, input logic b, input logic [31:0] bt,
    input logic j, input logic c, input logic [31:0] jt, input logic r,
    input logic [31:0] epc, input logic erd, input logic ee, input logic ef,
    input logic eo, input logic eu);
    vec_t v;
    v.stall = s; v.trap = t; v.br = b; v.bt = bt;
    v.jump = j; v.call = c; v.jt = jt; v.ret = r;
    v.exp_pc = epc; v.exp_redir = erd; v.exp_empty = ee;
    v.exp_full = ef; v.exp_ovf = eo; v.exp_unf = eu;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic t, input logic b,
                       input logic [31:0] bt, input logic j, input logic c,
                       input logic [31:0] jt, input logic r);
    stall = s; trap = t; branch_taken = b; branch_target = bt;
    jump = j; call = c; jump_target = jt; ret = r;
  endtask

  // Behavioural next state from the priority rules; RAS kept as a plain
  // LIFO queue where an overflowing push drops the oldest element.
  task automatic model_step();
    logic [31:0] link;
    link    = m_pc + 32'd4;
    m_redir = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    if (trap) begin
      m_pc = 32'h80; m_redir = 1'b1;
    end else if (stall) begin
      m_pc = m_pc;
    end else if (branch_taken) begin
      m_pc = branch_target & ~32'd3; m_redir = 1'b1;
    end else if (ret) begin
      if (m_ras.size() > 0) begin
        m_pc = m_ras.pop_back() & ~32'd3; m_redir = 1'b1;
      end else begin
        m_pc = link; m_unf = 1'b1;
      end
    end else if (jump) begin
      if (call) begin
        if (m_ras.size() == DEPTH) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
        m_ras.push_back(link);
      end
      m_pc = jump_target & ~32'd3; m_redir = 1'b1;
    end else begin
      m_pc = link;
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ras.delete();
    m_redir = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},       pc,        m_pc);
    check({tag, ".pc_plus4"}, pc_plus4,  m_pc + 32'd4);
    check({tag, ".redirect"}, {31'd0, redirect},  {31'd0, m_redir});
    check({tag, ".empty"},    {31'd0, ras_empty}, {31'd0, m_ras.size() == 0});
    check({tag, ".full"},     {31'd0, ras_full},  {31'd0, m_ras.size() == DEPTH});
    check({tag, ".ovf"},      {31'd0, ras_ovf},   {31'd0, m_ovf});
    check({tag, ".unf"},      {31'd0, ras_unf},   {31'd0, m_unf});
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //              s  t  b  bt            j  c  jt            r  exp_pc        rd e  f  o  u
    vecs[0]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h4,        0, 1, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h8,        0, 1, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'hC,        0, 1, 0, 0, 0);
    vecs[3]  = mk(0, 0, 1, 32'h20,       0, 0, 32'h0,        0, 32'h20,       1, 1, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 32'h0,        1, 1, 32'h100,      0, 32'h100,      1, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h24,       1, 1, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 32'h0,        1, 1, 32'h200,      0, 32'h200,      1, 0, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 32'h0,        1, 1, 32'h300,      0, 32'h300,      1, 0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 32'h0,        1, 1, 32'h400,      0, 32'h400,      1, 0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 32'h0,        1, 1, 32'h500,      0, 32'h500,      1, 0, 1, 0, 0);
    vecs[10] = mk(0, 0, 0, 32'h0,        1, 1, 32'h600,      0, 32'h600,      1, 0, 1, 1, 0);
    vecs[11] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h504,      1, 0, 0, 0, 0);
    vecs[12] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h404,      1, 0, 0, 0, 0);
    vecs[13] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h304,      1, 0, 0, 0, 0);
    vecs[14] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h204,      1, 1, 0, 0, 0);
    vecs[15] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h208,      0, 1, 0, 0, 1);
    vecs[16] = mk(1, 0, 1, 32'h40,       0, 0, 32'h0,        0, 32'h208,      0, 1, 0, 0, 0);
    vecs[17] = mk(1, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h80,       1, 1, 0, 0, 0);
    vecs[18] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h84,       0, 1, 0, 0, 0);
    vecs[19] = mk(0, 0, 0, 32'h0,        1, 1, 32'h1000,     0, 32'h1000,     1, 0, 0, 0, 0);
    vecs[20] = mk(0, 1, 1, 32'h40,       1, 1, 32'h2000,     1, 32'h80,       1, 0, 0, 0, 0);
    vecs[21] = mk(0, 0, 1, 32'h103,      0, 0, 32'h0,        0, 32'h100,      1, 0, 0, 0, 0);
    vecs[22] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h88,       1, 1, 0, 0, 0);
    vecs[23] = mk(0, 0, 0, 32'h0,        0, 1, 32'h3000,     0, 32'h8C,       0, 1, 0, 0, 0);
    vecs[24] = mk(0, 0, 1, 32'hFFFFFFFC, 0, 0, 32'h0,        0, 32'hFFFFFFFC, 1, 1, 0, 0, 0);
    vecs[25] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 0, 0);

    rst_n = 1'b0;
    drive(0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    model_reset();
    #12 rst_n = 1'b1;
    #1;
    check("reset.pc",       pc,       32'h0);
    check("reset.pc_plus4", pc_plus4, 32'h4);
    check("reset.redirect", {31'd0, redirect},  32'd0);
    check("reset.empty",    {31'd0, ras_empty}, 32'd1);
    check("reset.full",     {31'd0, ras_full},  32'd0);
    check("reset.ovf_unf",  {30'd0, ras_ovf, ras_unf}, 32'd0);

    foreach (vecs[k]) begin
      drive(vecs[k].stall, vecs[k].trap, vecs[k].br, vecs[k].bt,
            vecs[k].jump, vecs[k].call, vecs[k].jt, vecs[k].ret);
      step();
      check($sformatf("vec%0d.pc", k),       pc,       vecs[k].exp_pc);
      check($sformatf("vec%0d.pc_plus4", k), pc_plus4, vecs[k].exp_pc + 32'd4);
      check($sformatf("vec%0d.redirect", k), {31'd0, redirect},  {31'd0, vecs[k].exp_redir});
      check($sformatf("vec%0d.empty", k),    {31'd0, ras_empty}, {31'd0, vecs[k].exp_empty});
      check($sformatf("vec%0d.full", k),     {31'd0, ras_full},  {31'd0, vecs[k].exp_full});
      check($sformatf("vec%0d.ovf", k),      {31'd0, ras_ovf},   {31'd0, vecs[k].exp_ovf});
      check($sformatf("vec%0d.unf", k),      {31'd0, ras_unf},   {31'd0, vecs[k].exp_unf});
    end

    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(7) == 0, $urandom_range(15) == 0,
            $urandom_range(5) == 0, $urandom,
            $urandom_range(3) == 0, $urandom_range(1) == 1, $urandom,
            $urandom_range(2) == 0);
      step();
      check_model($sformatf("rnd%0d", i));
    end

    // Fill the RAS a bit, then pull reset between edges.
    drive(0, 0, 0, 32'h0, 1, 1, 32'h700, 0);
    step();
    check_model("pre_rst0");
    drive(0, 0, 0, 32'h0, 1, 1, 32'h800, 0);
    step();
    check_model("pre_rst1");
    drive(0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst.pc",       pc,       32'h0);
    check("async_rst.pc_plus4", pc_plus4, 32'h4);
    check("async_rst.empty",    {31'd0, ras_empty}, 32'd1);
    check("async_rst.redirect", {31'd0, redirect},  32'd0);
    #1 rst_n = 1'b1;
    model_reset();
    drive(0, 0, 0, 32'h0, 0, 0, 32'h0, 1);
    step();
    check_model("post_rst_ret");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
